// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use bubbles, multi-cycle mul/div holds,
// and branch flushes for a 5-stage in-order core. Control outputs are
// combinational in state and inputs; only the FSM state, the mul/div
// cycle counter, the timeout flag and the stall counter are registered.
module hazard_control_unit #(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_muldiv,
  input  logic             md_done,
  input  logic             ex_branch_taken,
  output logic             md_start,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_stall,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MDWAIT  = 2'd2
  } state_t;

  // Wide enough to hold MD_MAX_CYCLES itself.
  localparam int MDC_W = $clog2(MD_MAX_CYCLES + 1);

  state_t           state;
  state_t           state_nxt;
  logic [MDC_W-1:0] md_cnt;

  logic load_use;
  logic md_expired;
  logic set_timeout;

  // Un-gated control terms; reset gating is applied at the ports.
  logic c_md_start;
  logic c_pc_stall;
  logic c_if_id_stall;
  logic c_if_id_flush;
  logic c_id_ex_flush;
  logic c_ex_stall;

  // A load into x0 never produces a usable value, so it cannot cause a hazard.
  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == id_ex_rd)));

  assign md_expired = (md_cnt == MDC_W'(MD_MAX_CYCLES));

  // Next-state and control decode; branch beats mul/div beats load-use.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt     = state;
    set_timeout   = 1'b0;
    c_md_start    = 1'b0;
    c_pc_stall    = 1'b0;
    c_if_id_stall = 1'b0;
    c_if_id_flush = 1'b0;
    c_id_ex_flush = 1'b0;
    c_ex_stall    = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_branch_taken) begin
          c_if_id_flush = 1'b1;
          c_id_ex_flush = 1'b1;
        end else if (id_ex_muldiv) begin
          c_md_start    = 1'b1;
          c_pc_stall    = 1'b1;
          c_if_id_stall = 1'b1;
          c_ex_stall    = 1'b1;
          state_nxt     = MDWAIT;
        end else if (load_use) begin
          c_pc_stall    = 1'b1;
          c_if_id_stall = 1'b1;
          c_id_ex_flush = 1'b1;
          state_nxt     = LDSTALL;
        end
      end
      // The bubble is already in EX; let the dependent instruction go.
      LDSTALL: state_nxt = RUN;
      MDWAIT: begin
        if (md_done) begin
          state_nxt = RUN;
        end else if (md_expired) begin
          set_timeout = 1'b1;
          state_nxt   = RUN;
        end else begin
          c_pc_stall    = 1'b1;
          c_if_id_stall = 1'b1;
          c_ex_stall    = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Reset forces every control output low immediately, even mid-hold.
  assign md_start    = rst_n && c_md_start;
  assign pc_stall    = rst_n && c_pc_stall;
  assign if_id_stall = rst_n && c_if_id_stall;
  assign if_id_flush = rst_n && c_if_id_flush;
  assign id_ex_flush = rst_n && c_id_ex_flush;
  assign ex_stall    = rst_n && c_ex_stall;

  // FSM state and mul/div hold-cycle counter (the start cycle counts as 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (c_md_start)
        md_cnt <= MDC_W'(1);
      else if ((state == MDWAIT) && (state_nxt == MDWAIT))
        md_cnt <= md_cnt + MDC_W'(1);
      else
        md_cnt <= '0;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      md_timeout <= 1'b0;
    else if (set_timeout)
      md_timeout <= 1'b1;
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (pc_stall && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Inputs change on the falling
// edge; combinational outputs are checked 1ns later, before the next
// rising edge. Control vector order:
// {md_start, pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall}.
module tb_hazard_control_unit;

  localparam int CNT_W = 32;
  localparam int MDMAX = 40;

  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b011010;
  localparam logic [5:0] C_BR   = 6'b000110;
  localparam logic [5:0] C_MDS  = 6'b111001;
  localparam logic [5:0] C_MDW  = 6'b011001;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, id_ex_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             id_ex_mem_read, id_ex_muldiv, md_done, ex_branch_taken;
  logic             md_start, pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [5:0]       ctl;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  hazard_control_unit #(.MD_MAX_CYCLES(MDMAX), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_muldiv   (id_ex_muldiv),
    .md_done        (md_done),
    .ex_branch_taken(ex_branch_taken),
    .md_start       (md_start),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_stall       (ex_stall),
    .md_timeout     (md_timeout),
    .stall_count    (stall_count)
  );

  assign ctl = {md_start, pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check control outputs against exp, then advance to the
  // next falling edge. Tracks the expected stall count alongside.
  task automatic cyc(input string tag, input logic [5:0] exp);
    #1;
    check(tag, {26'd0, ctl}, {26'd0, exp});
    if (exp[4]) exp_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_muldiv = 1'b0;
    md_done = 1'b0; ex_branch_taken = 1'b0;
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    // Hazard inputs asserted during reset must not reach the outputs.
    id_ex_muldiv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ctl", {26'd0, ctl}, 32'd0);
    check("rst_cnt", stall_count, 32'd0);
    check("rst_to", {31'd0, md_timeout}, 32'd0);
    id_ex_muldiv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle", C_IDLE);

    // Load-use on rs1: one bubble, then LDSTALL ignores the same inputs.
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    cyc("lu_rs1", C_LU);
    cyc("lu_rs1_ldstall", C_IDLE);
    clr_inputs();
    check("lu_rs1_cnt", stall_count, 32'd1);

    // rs2 match but not used -> no hazard; used -> hazard.
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    cyc("lu_rs2_unused", C_IDLE);
    id_uses_rs2 = 1'b1;
    cyc("lu_rs2", C_LU);
    cyc("lu_rs2_ldstall", C_IDLE);
    clr_inputs();

    // Non-load producer matching rs1 -> no hazard.
    id_ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    cyc("no_load", C_IDLE);
    clr_inputs();

    // Load into x0 -> never a hazard.
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    cyc("lu_x0", C_IDLE);
    clr_inputs();

    // Branch beats load-use; state stays RUN so a following load-use stalls.
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    cyc("br_lu", C_BR);
    ex_branch_taken = 1'b0;
    cyc("br_then_lu", C_LU);
    clr_inputs();
    cyc("br_then_lu_ldstall", C_IDLE);

    // Branch beats mul/div: no start pulse.
    id_ex_muldiv = 1'b1; ex_branch_taken = 1'b1;
    cyc("br_md", C_BR);
    clr_inputs();

    // md_done outside MDWAIT is ignored.
    md_done = 1'b1;
    cyc("md_done_idle", C_IDLE);
    clr_inputs();
    check("cnt_pre_md", stall_count, exp_cnt);

    // Mul/div: start in cycle 0, held through 8, md_done releases cycle 9.
    id_ex_muldiv = 1'b1;
    cyc("md_start", C_MDS);
    for (int i = 1; i <= 8; i++) cyc("md_wait", C_MDW);
    md_done = 1'b1;
    cyc("md_done_release", C_IDLE);
    clr_inputs();
    cyc("md_after", C_IDLE);
    check("md_cnt", stall_count, exp_cnt);
    check("md_cnt_delta9", stall_count - 32'(exp_cnt - 9), 32'd9);
    check("md_no_to", {31'd0, md_timeout}, 32'd0);

    // Timeout: no md_done; held cycles 0..39, released in cycle 40.
    id_ex_muldiv = 1'b1;
    cyc("to_start", C_MDS);
    for (int i = 1; i < MDMAX; i++) cyc("to_wait", C_MDW);
    check("to_not_yet", {31'd0, md_timeout}, 32'd0);
    cyc("to_release", C_IDLE);
    clr_inputs();
    check("to_set", {31'd0, md_timeout}, 32'd1);
    cyc("to_idle1", C_IDLE);
    md_done = 1'b1;
    cyc("to_idle2", C_IDLE);
    clr_inputs();
    check("to_sticky", {31'd0, md_timeout}, 32'd1);
    check("to_cnt", stall_count, exp_cnt);

    // Async reset in MDWAIT cycle 3: outputs drop before the next edge.
    id_ex_muldiv = 1'b1;
    cyc("rst_md_start", C_MDS);
    cyc("rst_md_w1", C_MDW);
    cyc("rst_md_w2", C_MDW);
    #1;
    check("rst_md_w3", {26'd0, ctl}, {26'd0, C_MDW});
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {26'd0, ctl}, 32'd0);
    check("rst_async_cnt", stall_count, 32'd0);
    check("rst_async_to", {31'd0, md_timeout}, 32'd0);
    clr_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    cyc("post_rst_idle", C_IDLE);
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd12; id_rs2 = 5'd12; id_uses_rs2 = 1'b1;
    cyc("post_rst_lu", C_LU);
    cyc("post_rst_ldstall", C_IDLE);
    clr_inputs();
    check("post_rst_cnt", stall_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
